// File: rtl/axi_lite_mem_arbiter.sv
// rtl/axi_lite_mem_arbiter.sv - 2:1 AXI-lite arbiter (IFU read-only, LSU read/write) in front of the SRAM slave
// One transaction in flight; the granted master is routed combinationally, everything else is held at 0.
module axi_lite_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_arvalid,
  input  logic [AW-1:0] ifu_araddr,
  output logic          ifu_arready,
  output logic          ifu_rvalid,
  output logic [DW-1:0] ifu_rdata,
  input  logic          ifu_rready,
  input  logic          lsu_arvalid,
  input  logic [AW-1:0] lsu_araddr,
  output logic          lsu_arready,
  output logic          lsu_rvalid,
  output logic [DW-1:0] lsu_rdata,
  input  logic          lsu_rready,
  input  logic          lsu_awvalid,
  input  logic [AW-1:0] lsu_awaddr,
  output logic          lsu_awready,
  input  logic          lsu_wvalid,
  input  logic [DW-1:0] lsu_wdata,
  input  logic [SW-1:0] lsu_wstrb,
  output logic          lsu_wready,
  output logic          lsu_bvalid,
  input  logic          lsu_bready,
  output logic          SRAM_arvalid,
  output logic [AW-1:0] SRAM_araddr,
  input  logic          SRAM_arready,
  input  logic          SRAM_rvalid,
  input  logic [DW-1:0] SRAM_rdata,
  output logic          SRAM_rready,
  output logic          SRAM_awvalid,
  output logic [AW-1:0] SRAM_awaddr,
  input  logic          SRAM_awready,
  output logic          SRAM_wvalid,
  output logic [DW-1:0] SRAM_wdata,
  output logic [SW-1:0] SRAM_wstrb,
  input  logic          SRAM_wready,
  input  logic          SRAM_bvalid,
  output logic          SRAM_bready
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_IFU_RD = 2'd1;
  localparam logic [1:0] S_LSU_RD = 2'd2;
  localparam logic [1:0] S_LSU_WR = 2'd3;

  localparam logic RD_IFU = 1'b0;
  localparam logic RD_LSU = 1'b1;

  logic [1:0] state_q, state_d;
  logic       last_rd_q, last_rd_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_rd_q <= RD_LSU;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    case (state_q)
      S_IDLE: begin
        // A half-presented write (aw or w alone) already wins the grant.
        if (lsu_awvalid || lsu_wvalid) begin
          state_d = S_LSU_WR;
        end else if (lsu_arvalid && ifu_arvalid) begin
          if (last_rd_q == RD_LSU) begin
            state_d   = S_IFU_RD;
            last_rd_d = RD_IFU;
          end else begin
            state_d   = S_LSU_RD;
            last_rd_d = RD_LSU;
          end
        end else if (ifu_arvalid) begin
          state_d   = S_IFU_RD;
          last_rd_d = RD_IFU;
        end else if (lsu_arvalid) begin
          state_d   = S_LSU_RD;
          last_rd_d = RD_LSU;
        end
      end
      S_IFU_RD: if (SRAM_rvalid && ifu_rready) state_d = S_IDLE;
      S_LSU_RD: if (SRAM_rvalid && lsu_rready) state_d = S_IDLE;
      S_LSU_WR: if (SRAM_bvalid && lsu_bready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ifu_arready  = 1'b0;
    ifu_rvalid   = 1'b0;
    ifu_rdata    = '0;
    lsu_arready  = 1'b0;
    lsu_rvalid   = 1'b0;
    lsu_rdata    = '0;
    lsu_awready  = 1'b0;
    lsu_wready   = 1'b0;
    lsu_bvalid   = 1'b0;
    SRAM_arvalid = 1'b0;
    SRAM_araddr  = '0;
    SRAM_rready  = 1'b0;
    SRAM_awvalid = 1'b0;
    SRAM_awaddr  = '0;
    SRAM_wvalid  = 1'b0;
    SRAM_wdata   = '0;
    SRAM_wstrb   = '0;
    SRAM_bready  = 1'b0;
    case (state_q)
      S_IFU_RD: begin
        SRAM_arvalid = ifu_arvalid;
        SRAM_araddr  = ifu_araddr;
        ifu_arready  = SRAM_arready;
        ifu_rvalid   = SRAM_rvalid;
        ifu_rdata    = SRAM_rdata;
        SRAM_rready  = ifu_rready;
      end
      S_LSU_RD: begin
        SRAM_arvalid = lsu_arvalid;
        SRAM_araddr  = lsu_araddr;
        lsu_arready  = SRAM_arready;
        lsu_rvalid   = SRAM_rvalid;
        lsu_rdata    = SRAM_rdata;
        SRAM_rready  = lsu_rready;
      end
      S_LSU_WR: begin
        SRAM_awvalid = lsu_awvalid;
        SRAM_awaddr  = lsu_awaddr;
        lsu_awready  = SRAM_awready;
        SRAM_wvalid  = lsu_wvalid;
        SRAM_wdata   = lsu_wdata;
        SRAM_wstrb   = lsu_wstrb;
        lsu_wready   = SRAM_wready;
        lsu_bvalid   = SRAM_bvalid;
        SRAM_bready  = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// tb/tb_axi_lite_mem_arbiter.sv - directed bench for axi_lite_mem_arbiter with a small SRAM slave model
module tb_axi_lite_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_arvalid = 1'b0, ifu_rready = 1'b0;
  logic [31:0] ifu_araddr = '0;
  logic        ifu_arready, ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        lsu_arvalid = 1'b0, lsu_rready = 1'b0;
  logic [31:0] lsu_araddr = '0;
  logic        lsu_arready, lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        lsu_awvalid = 1'b0, lsu_wvalid = 1'b0, lsu_bready = 1'b0;
  logic [31:0] lsu_awaddr = '0, lsu_wdata = '0;
  logic [7:0]  lsu_wstrb = '0;
  logic        lsu_awready, lsu_wready, lsu_bvalid;
  logic        SRAM_arvalid, SRAM_rready, SRAM_awvalid, SRAM_wvalid, SRAM_bready;
  logic [31:0] SRAM_araddr, SRAM_awaddr, SRAM_wdata;
  logic [7:0]  SRAM_wstrb;
  logic        SRAM_arready, SRAM_awready, SRAM_wready;
  logic        s_rvalid, s_bvalid, aw_got, w_got;
  logic [31:0] s_rdata, s_awaddr, s_wdata;
  logic [7:0]  s_wstrb;
  logic [31:0] mem [0:15];

  int checks = 0;
  int errors = 0;
  int seq = 0;
  int ar_cnt = 0, b_cnt = 0, lsu_act_cnt = 0;

  axi_lite_mem_arbiter #(.AW(32), .DW(32), .SW(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rready(lsu_rready),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awready(lsu_awready),
    .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wready(lsu_wready),
    .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .SRAM_arvalid(SRAM_arvalid), .SRAM_araddr(SRAM_araddr), .SRAM_arready(SRAM_arready),
    .SRAM_rvalid(s_rvalid), .SRAM_rdata(s_rdata), .SRAM_rready(SRAM_rready),
    .SRAM_awvalid(SRAM_awvalid), .SRAM_awaddr(SRAM_awaddr), .SRAM_awready(SRAM_awready),
    .SRAM_wvalid(SRAM_wvalid), .SRAM_wdata(SRAM_wdata), .SRAM_wstrb(SRAM_wstrb),
    .SRAM_wready(SRAM_wready), .SRAM_bvalid(s_bvalid), .SRAM_bready(SRAM_bready)
  );

  always #5 clk = ~clk;

  wire [179:0] all_out = {ifu_arready, ifu_rvalid, ifu_rdata, lsu_arready, lsu_rvalid, lsu_rdata,
                          lsu_awready, lsu_wready, lsu_bvalid, SRAM_arvalid, SRAM_araddr, SRAM_rready,
                          SRAM_awvalid, SRAM_awaddr, SRAM_wvalid, SRAM_wdata, SRAM_wstrb, SRAM_bready};
  wire lsu_act = lsu_arready | lsu_rvalid | (|lsu_rdata) | lsu_awready | lsu_wready | lsu_bvalid;

  // SRAM model: one-cycle read latency, aw and w accepted independently, then one b response.
  assign SRAM_arready = !s_rvalid;
  assign SRAM_awready = !aw_got && !s_bvalid;
  assign SRAM_wready  = !w_got && !s_bvalid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_rvalid <= 1'b0; s_rdata <= 32'h5A5A_5A5A; s_bvalid <= 1'b0;
      aw_got <= 1'b0; w_got <= 1'b0; s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + i;
    end else begin
      if (SRAM_arvalid && !s_rvalid) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[SRAM_araddr[5:2]];
      end else if (s_rvalid && SRAM_rready) begin
        s_rvalid <= 1'b0;
      end
      if (aw_got && w_got && !s_bvalid) begin
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) mem[s_awaddr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
        s_bvalid <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (SRAM_awvalid && SRAM_awready) begin aw_got <= 1'b1; s_awaddr <= SRAM_awaddr; end
        if (SRAM_wvalid && SRAM_wready) begin w_got <= 1'b1; s_wdata <= SRAM_wdata; s_wstrb <= SRAM_wstrb; end
      end
      if (s_bvalid && SRAM_bready) s_bvalid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (SRAM_arvalid) ar_cnt++;
    if (lsu_bvalid && lsu_bready) b_cnt++;
    if (lsu_act) lsu_act_cnt++;
  end

  task automatic do_rd(input bit lsu, input logic [31:0] addr, input int stall,
                       output logic [31:0] data, output int ord);
    bit hs_ar, hs_r, rv, rr, started, raise, done;
    logic [31:0] rd, first;
    int held;
    started = 0; held = 0; done = 0; data = '0; ord = -1; first = '0;
    if (lsu) begin lsu_arvalid = 1; lsu_araddr = addr; lsu_rready = (stall == 0); end
    else begin ifu_arvalid = 1; ifu_araddr = addr; ifu_rready = (stall == 0); end
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      hs_ar = lsu ? (lsu_arvalid & lsu_arready) : (ifu_arvalid & ifu_arready);
      rv    = lsu ? lsu_rvalid : ifu_rvalid;
      rr    = lsu ? lsu_rready : ifu_rready;
      rd    = lsu ? lsu_rdata : ifu_rdata;
      hs_r  = rv & rr;
      raise = 0;
      if (rv && !rr) begin
        if (!started) begin
          started = 1; first = rd; held = 1;
        end else begin
          held++;
          checks++;
          if (rd !== first || (lsu ? (ifu_arready | ifu_rvalid) : (lsu_arready | lsu_rvalid))) begin
            errors++;
            $display("FAIL stall_hold lsu=%0d rdata=%h want %h other_side_active", lsu, rd, first);
          end
        end
        if (held >= stall) raise = 1;
      end
      if (hs_r) begin data = rd; ord = seq; seq++; end
      @(posedge clk); #1;
      if (hs_ar) begin if (lsu) lsu_arvalid = 0; else ifu_arvalid = 0; end
      if (raise) begin if (lsu) lsu_rready = 1; else ifu_rready = 1; end
      if (hs_r) begin
        if (lsu) lsu_rready = 0; else ifu_rready = 0;
        done = 1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL rd_timeout lsu=%0d addr=%h got no response want rvalid", lsu, addr);
      if (lsu) begin lsu_arvalid = 0; lsu_rready = 0; end else begin ifu_arvalid = 0; ifu_rready = 0; end
    end
  endtask

  task automatic do_wr(input logic [31:0] addr, input logic [31:0] wd, input logic [7:0] strb,
                       input int aw_lag, output int ord);
    bit hs_aw, hs_w, hs_b, done;
    done = 0; ord = -1;
    lsu_awaddr = addr; lsu_wdata = wd; lsu_wstrb = strb;
    lsu_wvalid = 1; lsu_awvalid = (aw_lag == 0); lsu_bready = 1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      hs_aw = lsu_awvalid & lsu_awready;
      hs_w  = lsu_wvalid & lsu_wready;
      hs_b  = lsu_bvalid & lsu_bready;
      if (hs_b) begin ord = seq; seq++; end
      @(posedge clk); #1;
      if (hs_aw) lsu_awvalid = 0;
      if (hs_w) lsu_wvalid = 0;
      if (aw_lag > 0 && n + 1 == aw_lag) lsu_awvalid = 1;
      if (hs_b) begin lsu_bready = 0; done = 1; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wr_timeout addr=%h got no bvalid want bvalid", addr);
      lsu_awvalid = 0; lsu_wvalid = 0; lsu_bready = 0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1;
    ifu_arvalid = 1; ifu_araddr = 32'hFFFF_FFFC; lsu_awvalid = 1; lsu_wvalid = 1;
    lsu_awaddr = 32'h1234_5678; lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 8'hFF; lsu_bready = 1;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", all_out); end
    ifu_arvalid = 0; lsu_awvalid = 0; lsu_wvalid = 0; lsu_bready = 0; ifu_rready = 1; lsu_rready = 1;
    rst = 0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL idle_outputs got %h want 0", all_out); end
    ifu_rready = 0; lsu_rready = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_ifu_alone();
    logic [31:0] d; int o, act0;
    act0 = lsu_act_cnt;
    do_rd(0, 32'h8000_0000, 0, d, o);
    checks++;
    if (d !== 32'hA000_0000) begin errors++; $display("FAIL ifu_alone_data got %h want a0000000", d); end
    checks++;
    if (lsu_act_cnt != act0) begin errors++; $display("FAIL ifu_alone_lsu_quiet got %0d active cycles want 0", lsu_act_cnt - act0); end
  endtask

  task automatic test_alternate();
    logic [31:0] di, dl; int oi, ol;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      fork
        do_rd(0, 32'h8000_0004, 0, di, oi);
        do_rd(1, 32'h8000_0008, 0, dl, ol);
      join
      checks++;
      if (!(oi >= 0 && ol > oi)) begin errors++; $display("FAIL alt_order round=%0d got ifu=%0d lsu=%0d want ifu first", r, oi, ol); end
      checks++;
      if (di !== 32'hA000_0001 || dl !== 32'hA000_0002) begin
        errors++; $display("FAIL alt_data round=%0d got %h %h want a0000001 a0000002", r, di, dl);
      end
    end
  endtask

  task automatic test_write_priority();
    logic [31:0] d; int ow, or_;
    fork
      do_wr(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, ow);
      do_rd(0, 32'h8000_0010, 0, d, or_);
    join
    checks++;
    if (!(ow >= 0 && or_ > ow)) begin errors++; $display("FAIL wr_first got wr=%0d rd=%0d want write first", ow, or_); end
    checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_readback got %h want deadbeef", d); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; int o, ar0, b0;
    ar0 = ar_cnt; b0 = b_cnt;
    do_wr(32'h8000_0020, 32'h1234_5678, 8'h03, 3, o);
    checks++;
    if (ar_cnt != ar0) begin errors++; $display("FAIL wlead_no_ar got %0d ar cycles want 0", ar_cnt - ar0); end
    checks++;
    if (b_cnt - b0 != 1) begin errors++; $display("FAIL wlead_bcount got %0d want 1", b_cnt - b0); end
    do_rd(0, 32'h8000_0020, 0, d, o);
    checks++;
    if (d !== 32'hA000_5678) begin errors++; $display("FAIL wlead_strb_readback got %h want a0005678", d); end
  endtask

  task automatic test_rready_stall();
    logic [31:0] di, dl; int oi, ol;
    fork
      do_rd(0, 32'h8000_0030, 4, di, oi);
      begin
        @(posedge clk); #1;
        do_rd(1, 32'h8000_0034, 0, dl, ol);
      end
    join
    checks++;
    if (!(oi >= 0 && ol > oi)) begin errors++; $display("FAIL stall_order got ifu=%0d lsu=%0d want ifu first", oi, ol); end
    checks++;
    if (di !== 32'hA000_000C || dl !== 32'hA000_000D) begin
      errors++; $display("FAIL stall_data got %h %h want a000000c a000000d", di, dl);
    end
  endtask

  task automatic test_reset_mid_lsu_rd();
    logic [31:0] di, dl; int oi, ol;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_000C; lsu_rready = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checks++;
    if (lsu_rvalid !== 1'b1) begin errors++; $display("FAIL midrst_in_lsu_rd got rvalid=%b want 1", lsu_rvalid); end
    #1 rst = 1;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL midrst_outputs got %h want 0", all_out); end
    lsu_arvalid = 0;
    @(negedge clk); rst = 0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL midrst_idle got %h want 0", all_out); end
    @(posedge clk); #1;
    fork
      do_rd(0, 32'h8000_0000, 0, di, oi);
      do_rd(1, 32'h8000_000C, 0, dl, ol);
    join
    checks++;
    if (!(oi >= 0 && ol > oi)) begin errors++; $display("FAIL midrst_last_rd got ifu=%0d lsu=%0d want ifu first", oi, ol); end
    checks++;
    if (dl !== 32'hA000_0003) begin errors++; $display("FAIL midrst_reissue_data got %h want a0000003", dl); end
  endtask

  initial begin
    test_reset();
    test_ifu_alone();
    test_alternate();
    test_write_priority();
    test_w_before_aw();
    test_rready_stall();
    test_reset_mid_lsu_rd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
